blob_frame_feeder: RTL and testbench

Producer side of the blob-counting pixel interface. On a software/key request, it waits for the next CCD frame start and thresholds each grayscale pixel to one bit. It streams exactly one frame to the blob counter using the counter's start / data-valid / seq / proc handshake, then waits for the counter's result and latches the count for the display path. It sits between the CCD capture/grayscale stage and the blob counter in the DE2_115_CAMERA datapath.

---
 rtl/blob_frame_feeder.sv | 206 ++++++++++++++++++++
 tb/tb_blob_frame_feeder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_frame_feeder.sv
// -----------------------------------------------------------------------------
// blob_frame_feeder
//
// Producer side of the blob-counting pixel interface. On a count request it
// waits for the next CCD frame start, thresholds each grayscale pixel to one
// bit and streams exactly one frame (plus one trailing pad beat) to the blob
// counter. It then waits for the counter's result and latches the count for
// the display path.
//
// Handshake (towards the blob counter): o_valid is a one-cycle start pulse
// coincident with beat 0; o_data_valid qualifies o_seq on every beat (o_seq is
// 0 whenever o_data_valid is 0); o_proc_ccd is high from the cycle after the
// request is accepted until the cycle after i_blob_valid is first seen.
// i_blob_valid is a level; the feeder only returns to IDLE once it drops.
//
// Optional feature: define BLOB_FEED_TIMEOUT_EN to add a result watchdog. If
// TIMEOUT_CYC cycles pass in WAIT without i_blob_valid, o_count is loaded
// with 8'hFF, o_count_valid pulses and the FSM returns straight to IDLE.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start, i_threshold  count request (sampled in IDLE) and threshold
//   i_pix_valid, i_pix_gray, i_frame_start   grayscale pixel stream
//   o_valid, o_data_valid, o_seq, o_proc_ccd  blob counter handshake
//   i_blob_valid, i_blob_count                blob counter result
//   o_count, o_count_valid                    latched result and update pulse
//   o_busy                high in every state except IDLE
//   o_dbg_state           current FSM state encoding
// -----------------------------------------------------------------------------
module blob_frame_feeder #(
  parameter int IMG_COL     = 800,
  parameter int IMG_ROW     = 600,
  parameter int PIX_W       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PIX_W-1:0] i_threshold,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_gray,
  input  logic             i_frame_start,
  output logic             o_valid,
  output logic             o_data_valid,
  output logic             o_seq,
  output logic             o_proc_ccd,
  input  logic             i_blob_valid,
  input  logic [7:0]       i_blob_count,
  output logic [7:0]       o_count,
  output logic             o_count_valid,
  output logic             o_busy,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_STREAM  = 3'd2,
    S_PAD     = 3'd3,
    S_WAIT    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [9:0] COL_LAST = 10'(IMG_COL - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_ROW - 1);

  state_t           state_q, state_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic             valid_d, data_valid_d, seq_d, proc_d, count_valid_d, busy_d;
  logic [7:0]       count_d;
  logic             take_pix;
  logic             last_beat;

`ifdef BLOB_FEED_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_q, to_d;
`endif

  // A pixel becomes a beat either as the frame-start pixel seen in ARM, or as
  // any valid pixel in STREAM (a stray frame start there is just a pixel).
  assign take_pix  = ((state_q == S_ARM) && i_pix_valid && i_frame_start) ||
                     ((state_q == S_STREAM) && i_pix_valid);
  assign last_beat = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d       = state_q;
    thr_d         = thr_q;
    col_d         = col_q;
    row_d         = row_q;
    proc_d        = o_proc_ccd;
    count_d       = o_count;
    valid_d       = 1'b0;
    data_valid_d  = 1'b0;
    seq_d         = 1'b0;
    count_valid_d = 1'b0;
`ifdef BLOB_FEED_TIMEOUT_EN
    to_d          = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          thr_d   = i_threshold;
          proc_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (take_pix) begin
          valid_d = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: ;
      S_PAD: begin
        // The counter needs one beat past the last pixel to leave processing.
        data_valid_d = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (i_blob_valid) begin
          count_d       = i_blob_count;
          count_valid_d = 1'b1;
          proc_d        = 1'b0;
          state_d       = S_RELEASE;
        end
`ifdef BLOB_FEED_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          count_d       = 8'hFF;
          count_valid_d = 1'b1;
          proc_d        = 1'b0;
          state_d       = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        // Stay here until the counter drops its result, so a new request
        // cannot re-arm while the counter is still busy.
        if (!i_blob_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_pix) begin
      data_valid_d = 1'b1;
      seq_d        = (i_pix_gray >= thr_q);
      if (last_beat) begin
        col_d   = '0;
        row_d   = '0;
        state_d = S_PAD;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      thr_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      o_valid       <= 1'b0;
      o_data_valid  <= 1'b0;
      o_seq         <= 1'b0;
      o_proc_ccd    <= 1'b0;
      o_count       <= '0;
      o_count_valid <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      thr_q         <= thr_d;
      col_q         <= col_d;
      row_q         <= row_d;
      o_valid       <= valid_d;
      o_data_valid  <= data_valid_d;
      o_seq         <= seq_d;
      o_proc_ccd    <= proc_d;
      o_count       <= count_d;
      o_count_valid <= count_valid_d;
      o_busy        <= busy_d;
    end
  end

`ifdef BLOB_FEED_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) to_q <= '0;
    else       to_q <= to_d;
  end
`endif

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_blob_frame_feeder.sv
module tb_blob_frame_feeder;

  localparam int IMG_COL = 8;
  localparam int IMG_ROW = 4;
  localparam int N_PIX   = IMG_COL * IMG_ROW;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       st;
  logic [7:0] thr_in;
  logic       pv;
  logic [7:0] gray;
  logic       fs;
  logic       bv;
  logic [7:0] bc;
  logic       o_valid, o_data_valid, o_seq, o_proc_ccd;
  logic [7:0] o_count;
  logic       o_count_valid, o_busy;
  logic [2:0] o_dbg_state;

  // expected beat entries: {data_valid, start_pulse, seq}
  logic [2:0] exp_q[$];
  logic [2:0] e;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         beat_cnt = 0;
  int         cv_cnt   = 0;
  int         cv_before;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  blob_frame_feeder #(
    .IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .PIX_W(8), .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(st), .i_threshold(thr_in),
    .i_pix_valid(pv), .i_pix_gray(gray), .i_frame_start(fs),
    .o_valid(o_valid), .o_data_valid(o_data_valid), .o_seq(o_seq),
    .o_proc_ccd(o_proc_ccd), .i_blob_valid(bv), .i_blob_count(bc),
    .o_count(o_count), .o_count_valid(o_count_valid), .o_busy(o_busy),
    .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (o_count_valid) cv_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("beat_dv", 32'(o_data_valid), 32'(e[2]));
      check("beat_start", 32'(o_valid), 32'(e[1]));
      check("beat_seq", 32'(o_seq), 32'(e[0]));
      if (o_data_valid) beat_cnt++;
    end else begin
      check("stray_dv", 32'(o_data_valid), 32'd0);
      check("stray_start", 32'(o_valid), 32'd0);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_start(input logic [7:0] t);
    @(negedge clk);
    st = 1'b1; thr_in = t;
    @(negedge clk);
    st = 1'b0;
  endtask

  // Pixels alternate 0x7F / 0x80; with threshold 0x80 that is seq 0,1,0,1...
  task automatic drive_frame(input int n, input bit gaps, input bit mid_fs, input bit pad);
    for (int p = 0; p < n; p++) begin
      if (gaps && p > 0 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        pv = 1'b0; fs = 1'b0; gray = 8'($urandom_range(0, 255));
        exp_q.push_back(3'b000);
      end
      @(negedge clk);
      pv   = 1'b1;
      fs   = (p == 0) || (mid_fs && p == 13);
      gray = p[0] ? 8'h80 : 8'h7F;
      exp_q.push_back({1'b1, (p == 0), p[0]});
    end
    if (pad) begin
      @(negedge clk);
      pv = 1'b0; fs = 1'b0;
      exp_q.push_back(3'b100);
    end
  endtask

  task automatic blob_respond(input int delay, input logic [7:0] cnt, input int hold);
    cv_before = cv_cnt;
    repeat (delay) @(negedge clk);
    bv = 1'b1; bc = cnt;
    @(posedge clk); #1;
    check("res_cv", 32'(o_count_valid), 32'd1);
    check("res_count", 32'(o_count), 32'(cnt));
    check("res_proc_low", 32'(o_proc_ccd), 32'd0);
    check("res_state", 32'(o_dbg_state), 32'(ST_RELEASE));
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_cv", 32'(o_count_valid), 32'd0);
      check("hold_state", 32'(o_dbg_state), 32'(ST_RELEASE));
      check("hold_busy", 32'(o_busy), 32'd1);
    end
    @(negedge clk);
    bv = 1'b0; bc = 8'h00;
    @(posedge clk); #1;
    check("rel_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    check("rel_busy", 32'(o_busy), 32'd0);
    check("rel_count_held", 32'(o_count), 32'(cnt));
    check("cv_pulses", 32'(cv_cnt - cv_before), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_dv"}, 32'(o_data_valid), 32'd0);
    check({tag, "_seq"}, 32'(o_seq), 32'd0);
    check({tag, "_proc"}, 32'(o_proc_ccd), 32'd0);
    check({tag, "_count"}, 32'(o_count), 32'd0);
    check({tag, "_cv"}, 32'(o_count_valid), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_cmp++; n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; st = 1'b0; thr_in = 8'h00; pv = 1'b0; gray = 8'h00;
    fs = 1'b0; bv = 1'b0; bc = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // request with no frame: stays ARM, ignores pixels without frame start
    @(negedge clk);
    st = 1'b1; thr_in = 8'h80;
    @(posedge clk); #1;
    check("arm_busy", 32'(o_busy), 32'd1);
    check("arm_proc", 32'(o_proc_ccd), 32'd1);
    check("arm_state", 32'(o_dbg_state), 32'(ST_ARM));
    @(negedge clk);
    st = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pv = 1'b1; fs = 1'b0; gray = 8'hFF;
    end
    @(negedge clk);
    pv = 1'b0;
    @(posedge clk); #1;
    check("arm_hold_state", 32'(o_dbg_state), 32'(ST_ARM));
    check("arm_hold_dv", 32'(o_data_valid), 32'd0);

    // frame 1: no gaps
    beat_cnt = 0;
    drive_frame(N_PIX, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    // a request during WAIT must be ignored
    st = 1'b1; thr_in = 8'h00;
    @(negedge clk);
    st = 1'b0;
    @(posedge clk); #1;
    check("wait_ignores_start", 32'(o_dbg_state), 32'(ST_WAIT));
    check("wait_proc", 32'(o_proc_ccd), 32'd1);
    check("f1_beats", 32'(beat_cnt), 32'(N_PIX + 1));
    blob_respond(7, 8'd5, 3);

    // frame 2: random one-cycle gaps
    do_start(8'h80);
    beat_cnt = 0;
    drive_frame(N_PIX, 1'b1, 1'b0, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("f2_beats", 32'(beat_cnt), 32'(N_PIX + 1));
    check("f2_wait_state", 32'(o_dbg_state), 32'(ST_WAIT));
    blob_respond(2, 8'd3, 1);

    // reset while streaming, right after beat 10
    do_start(8'h80);
    drive_frame(11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    pv = 1'b0; fs = 1'b0; rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;

    // clean restart, with a stray frame start mid-frame
    do_start(8'h80);
    beat_cnt = 0;
    drive_frame(N_PIX, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("f3_beats", 32'(beat_cnt), 32'(N_PIX + 1));
    blob_respond(3, 8'd9, 2);

`ifdef BLOB_FEED_TIMEOUT_EN
    // watchdog: never answer; result 0xFF after 16 cycles in WAIT
    do_start(8'h80);
    drive_frame(N_PIX, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k < 16) begin
        check("to_cv_early", 32'(o_count_valid), 32'd0);
        check("to_state_wait", 32'(o_dbg_state), 32'(ST_WAIT));
      end else begin
        check("to_cv", 32'(o_count_valid), 32'd1);
        check("to_count", 32'(o_count), 32'hFF);
        check("to_proc", 32'(o_proc_ccd), 32'd0);
        check("to_state_idle", 32'(o_dbg_state), 32'(ST_IDLE));
      end
    end
`endif

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
